// File: rtl/section_input_pkg.sv
// Shared USRT receive definitions: frame constants, FSM state encoding and data-width helpers.
package section_input_pkg;

    localparam int unsigned USRT_STOP_BITS = 2;
    localparam int unsigned USRT_DATA_MAX  = 8;
    localparam int unsigned USRT_DATA_MIN  = 7;
    localparam int unsigned DATA_W         = USRT_DATA_MAX;
    localparam int unsigned BIT_CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STOP1 = 2'd2,
        ST_STOP2 = 2'd3
    } rx_state_e;

    // Index of the final data bit for the latched frame size.
    function automatic logic [BIT_CNT_W-1:0] last_idx(input logic size8);
        return size8 ? BIT_CNT_W'(USRT_DATA_MAX - 1) : BIT_CNT_W'(USRT_DATA_MIN - 1);
    endfunction

    // Mask of data bits that actually carry payload.
    function automatic logic [DATA_W-1:0] data_mask(input logic size8);
        return size8 ? DATA_W'(8'hFF) : DATA_W'(8'h7F);
    endfunction

endpackage

// File: rtl/section_input_hold.sv
// One-entry holding register for received bytes: valid/ready handshake with sticky overrun.
module section_input_hold
    import section_input_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              rx_ready,
    input  logic              err_clr,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              overrun
);

    logic pop_c;
    logic blocked_c;

    assign pop_c     = rx_valid & rx_ready;
    assign blocked_c = load & rx_valid & ~pop_c;

    // A load into a full, unpopped register drops the new byte and keeps the old one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (load && !blocked_c) begin
            rx_data  <= load_data;
            rx_valid <= 1'b1;
        end else if (pop_c) begin
            rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (blocked_c) begin
            overrun <= 1'b1;
        end else if (err_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/section_input.sv
// USRT receiver: samples rxd on usrt_pedge, checks two stop bits, hands bytes to a holding register.
// Optional macro USRT_RX_PATTERN_CHECK_EN adds the alternating all-0/all-1 frame checker (pattern_err).
module section_input
    import section_input_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              usrt_pedge,
    input  logic              size_flag,
    input  logic              rts,
    input  logic              rxd,
    input  logic              rx_ready,
    input  logic              err_clr,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  frame_cnt
`ifdef USRT_RX_PATTERN_CHECK_EN
    ,
    output logic              pattern_err
`endif
);

    rx_state_e             state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  size8_q, size8_d;
    logic                  err_set_c;
    logic                  deliver_c;
    logic [DATA_W-1:0]     byte_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            size8_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            size8_q   <= size8_d;
        end
    end

    // Frame FSM; only strobe cycles advance, any rts drop mid-frame aborts it.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        size8_d   = size8_q;
        err_set_c = 1'b0;
        deliver_c = 1'b0;
        if (usrt_pedge) begin
            case (state_q)
                ST_IDLE: begin
                    if (rts && !rxd) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        size8_d   = size_flag;
                    end
                end
                ST_DATA: begin
                    if (!rts) begin
                        err_set_c = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        shift_d[bit_cnt_q] = rxd;
                        bit_cnt_d          = BIT_CNT_W'(bit_cnt_q + 1'b1);
                        if (bit_cnt_q == last_idx(size8_q)) begin
                            state_d = ST_STOP1;
                        end
                    end
                end
                ST_STOP1: begin
                    if (!rts || !rxd) begin
                        err_set_c = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_STOP2;
                    end
                end
                ST_STOP2: begin
                    state_d = ST_IDLE;
                    if (!rts || !rxd) begin
                        err_set_c = 1'b1;
                    end else begin
                        deliver_c = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign byte_c = shift_q & data_mask(size8_q);

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (err_set_c) begin
            frame_err <= 1'b1;
        end else if (err_clr) begin
            frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (deliver_c) begin
            frame_cnt <= CNT_W'(frame_cnt + 1'b1);
        end
    end

    section_input_hold u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (deliver_c),
        .load_data (byte_c),
        .rx_ready  (rx_ready),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .overrun   (overrun)
    );

`ifdef USRT_RX_PATTERN_CHECK_EN
    logic last_pat_q;
    logic have_last_q;
    logic all0_c, all1_c, viol_c;

    assign all0_c = (byte_c == '0);
    assign all1_c = (byte_c == data_mask(size8_q));
    assign viol_c = deliver_c & (~(all0_c | all1_c) | (have_last_q & (all1_c == last_pat_q)));

    // Remember the polarity of the last uniform good frame so the next must be the opposite.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pat_q  <= 1'b0;
            have_last_q <= 1'b0;
        end else if (deliver_c && (all0_c || all1_c)) begin
            last_pat_q  <= all1_c;
            have_last_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_err <= 1'b0;
        end else if (viol_c) begin
            pattern_err <= 1'b1;
        end else if (err_clr) begin
            pattern_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_section_input.sv
// Directed bench for section_input: bit-level frame driver, byte scoreboard, flag and counter checks.
module tb_section_input;

    logic       clk = 1'b0;
    logic       rst;
    logic       usrt_pedge;
    logic       size_flag;
    logic       rts;
    logic       rxd;
    logic       rx_ready;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [7:0] frame_cnt;
`ifdef USRT_RX_PATTERN_CHECK_EN
    logic       pattern_err;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_cnt = 8'd0;

    always #5 clk = ~clk;

    section_input #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .usrt_pedge (usrt_pedge),
        .size_flag  (size_flag),
        .rts        (rts),
        .rxd        (rxd),
        .rx_ready   (rx_ready),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
`ifdef USRT_RX_PATTERN_CHECK_EN
        ,
        .pattern_err(pattern_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted pop is compared against the oldest expected byte.
    always begin
        @(negedge clk);
        #1;
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(rx_valid), 32'd0);
            end else begin
                chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic strobe(input logic rts_v, input logic rxd_v, input logic clr, input logic rdy);
        @(negedge clk);
        rts        = rts_v;
        rxd        = rxd_v;
        usrt_pedge = 1'b1;
        err_clr    = clr;
        if (rdy) rx_ready = 1'b1;
        @(negedge clk);
        usrt_pedge = 1'b0;
        err_clr    = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // One frame; drop_at >= 0 lowers rts on that data bit's strobe and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input logic s8, input logic st1, input logic st2,
                              input int drop_at, input logic push, input logic clr_last,
                              input logic rdy_last);
        int n;
        n = s8 ? 8 : 7;
        size_flag = s8;
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        size_flag = ~s8;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) begin
                strobe(1'b0, d[i], 1'b0, 1'b0);
                rts = 1'b0;
                rxd = 1'b1;
                return;
            end
            strobe(1'b1, d[i], 1'b0, 1'b0);
        end
        if (!st1) begin
            strobe(1'b1, 1'b0, clr_last, rdy_last);
            rts = 1'b0;
            rxd = 1'b1;
            return;
        end
        strobe(1'b1, 1'b1, 1'b0, 1'b0);
        if (st2) begin
            exp_cnt = exp_cnt + 8'd1;
            if (push) exp_q.push_back(s8 ? d : {1'b0, d[6:0]});
        end
        strobe(1'b1, st2, clr_last, rdy_last);
        rts = 1'b0;
        rxd = 1'b1;
    endtask

    task automatic good(input logic [7:0] d, input logic s8);
        send_frame(d, s8, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        usrt_pedge = 1'b0;
        size_flag  = 1'b0;
        rts        = 1'b0;
        rxd        = 1'b1;
        rx_ready   = 1'b1;
        err_clr    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(rx_valid), 32'd0);
        chk("reset_data", 32'(rx_data), 32'd0);
        chk("reset_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_ferr", 32'(frame_err), 32'd0);
        chk("reset_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1: back-to-back 8-bit frames
        good(8'h00, 1'b1);
        good(8'hFF, 1'b1);
        good(8'h00, 1'b1);
`ifndef USRT_RX_PATTERN_CHECK_EN
        good(8'hA5, 1'b1);
`endif
        chk("t1_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("t1_ferr", 32'(frame_err), 32'd0);
        chk("t1_ovr", 32'(overrun), 32'd0);

        // T2: 7-bit frames, bit 7 forced low
        good(8'h00, 1'b0);
        good(8'hFF, 1'b0);
`ifndef USRT_RX_PATTERN_CHECK_EN
        good(8'hAB, 1'b0);
`endif
        chk("t2_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("t2_bit7", 32'(rx_data[7]), 32'd0);

        // T3: second stop bit low, then clear and recover; error beats a simultaneous clear
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b0, 1'b0);
        chk("t3_valid", 32'(rx_valid), 32'd0);
        chk("t3_ferr", 32'(frame_err), 32'd1);
        chk("t3_cnt", 32'(frame_cnt), 32'(exp_cnt));
        pulse_clr();
        chk("t3_clr", 32'(frame_err), 32'd0);
        good(8'hFF, 1'b1);
        chk("t3_cnt2", 32'(frame_cnt), 32'(exp_cnt));
        send_frame(8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0);
        chk("t3_err_wins", 32'(frame_err), 32'd1);
        send_frame(8'h00, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0);
        chk("t3_stop1_cnt", 32'(frame_cnt), 32'(exp_cnt));
        pulse_clr();

        // T4: overrun keeps the first byte; then load and pop on the same edge
        rx_ready = 1'b0;
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0);
        chk("t4_hold_valid", 32'(rx_valid), 32'd1);
        chk("t4_ovr0", 32'(overrun), 32'd0);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        chk("t4_ovr1", 32'(overrun), 32'd1);
        chk("t4_kept", 32'(rx_data), 32'h00);
        chk("t4_cnt", 32'(frame_cnt), 32'(exp_cnt));
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_popped", 32'(rx_valid), 32'd0);
        pulse_clr();
        chk("t4_ovr_clr", 32'(overrun), 32'd0);
        rx_ready = 1'b0;
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b1);
        chk("t4_same_cycle_ovr", 32'(overrun), 32'd0);
        chk("t4_drained", 32'(rx_valid), 32'd0);

        // T5: rts dropped on data bit 3, next frame still received
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        chk("t5_ferr", 32'(frame_err), 32'd1);
        chk("t5_cnt", 32'(frame_cnt), 32'(exp_cnt));
        good(8'hFF, 1'b1);
        chk("t5_next_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // T6: asynchronous reset between strobes mid-frame
        size_flag = 1'b1;
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_cnt0", 32'(frame_cnt), 32'd0);
        chk("t6_ferr0", 32'(frame_err), 32'd0);
        chk("t6_valid0", 32'(rx_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rts = 1'b0;
        rxd = 1'b1;
        exp_cnt = 8'd0;
        @(negedge clk);
        good(8'hFF, 1'b1);
        chk("t6_next_cnt", 32'(frame_cnt), 32'(exp_cnt));
`ifdef USRT_RX_PATTERN_CHECK_EN
        chk("t6_pat_ok", 32'(pattern_err), 32'd0);
        good(8'hFF, 1'b1);
        chk("t6_pat_err", 32'(pattern_err), 32'd1);
`endif

        // Counter wrap
        while (exp_cnt != 8'd255) good(exp_cnt[0] ? 8'h00 : 8'hFF, 1'b1);
        chk("wrap_255", 32'(frame_cnt), 32'd255);
        good(8'h00, 1'b1);
        chk("wrap_0", 32'(frame_cnt), 32'd0);
        repeat (4) @(negedge clk);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
